// File: rtl/ldq_ctrl.sv
// -----------------------------------------------------------------------------
// ldq_ctrl -- load-queue allocation / retirement controller
//
// Tracks the circular load queue: head (oldest entry), tail (next free entry)
// and occupancy. Allocates up to four loads per dispatch bundle, retires up to
// two loads per cycle, and squashes every uncommitted load on recovery.
//
// Parameters
//   LDQ_DEPTH  number of load-queue entries (power of two, minimum 8)
//   LDQ_LOG    log2(LDQ_DEPTH)
//
// Ports
//   clk                   rising-edge clock
//   reset                 asynchronous active-low reset
//   dispatchReady_i       dispatch bundle valid this cycle
//   inst0Load_i..3        bundle slot i carries a load
//   commitCnt_i [1:0]     loads retiring this cycle (0..2 expected)
//   recoverFlag_i         squash all uncommitted loads
//   ldqHead_o             oldest entry index (registered)
//   ldqTail_o             next free entry index (registered)
//   ldqInsts_o            occupancy, 0..LDQ_DEPTH (registered)
//   dispatchAck_o         bundle accepted this cycle (combinational)
//   ldqStall_o            bundle present but not accepted (combinational)
//   ldqEmpty_o            occupancy is zero (registered)
//   commitErr_o           sticky: a commit asked for more loads than present
//   ldqState_o            FSM state for debug: 0=RUN, 1=STALL, 2=RECOVER
//
// Optional feature (macro LDQ_OCCUPANCY_STATS_EN):
//   ldqPeak_o             highest post-update occupancy since reset
//   ldqStallCycles_o      saturating count of cycles with ldqStall_o=1
//
// Dispatch handshake: dispatchReady_i is the valid. dispatchAck_o is the ready
// qualified by valid, so a bundle transfers in exactly the cycle where
// dispatchReady_i=1 and dispatchAck_o=1; ldqStall_o flags valid without
// acceptance and the bundle is expected to be held and re-presented.
// -----------------------------------------------------------------------------
module ldq_ctrl #(
    parameter int LDQ_DEPTH = 32,
    parameter int LDQ_LOG   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dispatchReady_i,
    input  logic               inst0Load_i,
    input  logic               inst1Load_i,
    input  logic               inst2Load_i,
    input  logic               inst3Load_i,
    input  logic [1:0]         commitCnt_i,
    input  logic               recoverFlag_i,
    output logic [LDQ_LOG-1:0] ldqHead_o,
    output logic [LDQ_LOG-1:0] ldqTail_o,
    output logic [LDQ_LOG:0]   ldqInsts_o,
    output logic               dispatchAck_o,
    output logic               ldqStall_o,
    output logic               ldqEmpty_o,
    output logic               commitErr_o,
    output logic [1:0]         ldqState_o
`ifdef LDQ_OCCUPANCY_STATS_EN
    ,
    output logic [LDQ_LOG:0]   ldqPeak_o,
    output logic [31:0]        ldqStallCycles_o
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        RECOVER = 2'd2
    } ldqState_e;

    localparam logic [LDQ_LOG:0] DEPTH_VAL = (LDQ_LOG+1)'(LDQ_DEPTH);

    ldqState_e          state;
    ldqState_e          stateNext;

    logic [2:0]         newLd;
    logic [LDQ_LOG:0]   ldqFree;
    logic               commitExceeds;
    logic [1:0]         effCommit;
    logic [2:0]         addLd;
    logic [LDQ_LOG-1:0] headNext;
    logic [LDQ_LOG-1:0] tailNext;
    logic [LDQ_LOG:0]   instsNext;

    assign ldqState_o = state;

    // ------------------------------------------------------------------
    // Bundle sizing and free space. Free space is taken from the occupancy
    // before this cycle's commits, so retiring loads never make room for a
    // bundle in the same cycle.
    // ------------------------------------------------------------------
    assign newLd   = 3'(inst0Load_i) + 3'(inst1Load_i)
                   + 3'(inst2Load_i) + 3'(inst3Load_i);
    assign ldqFree = DEPTH_VAL - ldqInsts_o;

    // A commit request larger than the occupancy is clamped; in that case
    // the occupancy is below 3 so its low two bits hold the whole value.
    assign commitExceeds = (LDQ_LOG+1)'(commitCnt_i) > ldqInsts_o;
    assign effCommit     = commitExceeds ? ldqInsts_o[1:0] : commitCnt_i;

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        dispatchAck_o = 1'b0;
        ldqStall_o    = 1'b0;
        stateNext     = state;

        if ((state == RUN || state == STALL) && dispatchReady_i &&
            !recoverFlag_i && ((LDQ_LOG+1)'(newLd) <= ldqFree)) begin
            dispatchAck_o = 1'b1;
        end
        ldqStall_o = dispatchReady_i & ~dispatchAck_o;

        if (recoverFlag_i) begin
            stateNext = RECOVER;
        end else begin
            case (state)
                RUN:     stateNext = ldqStall_o ? STALL : RUN;
                STALL:   stateNext = dispatchAck_o ? RUN : STALL;
                RECOVER: stateNext = RUN;
                default: stateNext = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Pointer and occupancy next values. Head always moves by the clamped
    // commit count; recovery drops everything still queued, so the tail
    // snaps to the post-commit head and the queue becomes empty.
    // ------------------------------------------------------------------
    always_comb begin
        addLd    = dispatchAck_o ? newLd : 3'd0;
        headNext = ldqHead_o + LDQ_LOG'(effCommit);
        tailNext = ldqTail_o + LDQ_LOG'(addLd);
        instsNext = ldqInsts_o + (LDQ_LOG+1)'(addLd) - (LDQ_LOG+1)'(effCommit);
        if (recoverFlag_i) begin
            tailNext  = headNext;
            instsNext = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ldqHead_o   <= '0;
            ldqTail_o   <= '0;
            ldqInsts_o  <= '0;
            ldqEmpty_o  <= 1'b1;
            commitErr_o <= 1'b0;
        end else begin
            ldqHead_o  <= headNext;
            ldqTail_o  <= tailNext;
            ldqInsts_o <= instsNext;
            // Full and empty both have head == tail; the registered empty
            // flag is what tells them apart.
            ldqEmpty_o <= (instsNext == '0);
            if (commitExceeds) begin
                commitErr_o <= 1'b1;
            end
        end
    end

`ifdef LDQ_OCCUPANCY_STATS_EN
    // ------------------------------------------------------------------
    // Occupancy statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ldqPeak_o        <= '0;
            ldqStallCycles_o <= '0;
        end else begin
            if (instsNext > ldqPeak_o) begin
                ldqPeak_o <= instsNext;
            end
            if (ldqStall_o && (ldqStallCycles_o != 32'hFFFF_FFFF)) begin
                ldqStallCycles_o <= ldqStallCycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ldq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ldq_ctrl -- self-checking bench for ldq_ctrl
//
// The reference keeps the load queue as a real queue of allocated entry
// indices plus a head pointer; occupancy is the queue size and the tail is
// head + size. Directed scenarios come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_ldq_ctrl;

    localparam int D = 32;
    localparam int L = 5;

    localparam int M_RUN     = 0;
    localparam int M_STALL   = 1;
    localparam int M_RECOVER = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         dispatchReady_i = 1'b0;
    logic         inst0Load_i = 1'b0;
    logic         inst1Load_i = 1'b0;
    logic         inst2Load_i = 1'b0;
    logic         inst3Load_i = 1'b0;
    logic [1:0]   commitCnt_i = 2'd0;
    logic         recoverFlag_i = 1'b0;
    logic [L-1:0] ldqHead_o;
    logic [L-1:0] ldqTail_o;
    logic [L:0]   ldqInsts_o;
    logic         dispatchAck_o;
    logic         ldqStall_o;
    logic         ldqEmpty_o;
    logic         commitErr_o;
    logic [1:0]   ldqState_o;
`ifdef LDQ_OCCUPANCY_STATS_EN
    logic [L:0]   ldqPeak_o;
    logic [31:0]  ldqStallCycles_o;
`endif

    ldq_ctrl #(.LDQ_DEPTH(D), .LDQ_LOG(L)) dut (
        .clk             (clk),
        .reset           (reset),
        .dispatchReady_i (dispatchReady_i),
        .inst0Load_i     (inst0Load_i),
        .inst1Load_i     (inst1Load_i),
        .inst2Load_i     (inst2Load_i),
        .inst3Load_i     (inst3Load_i),
        .commitCnt_i     (commitCnt_i),
        .recoverFlag_i   (recoverFlag_i),
        .ldqHead_o       (ldqHead_o),
        .ldqTail_o       (ldqTail_o),
        .ldqInsts_o      (ldqInsts_o),
        .dispatchAck_o   (dispatchAck_o),
        .ldqStall_o      (ldqStall_o),
        .ldqEmpty_o      (ldqEmpty_o),
        .commitErr_o     (commitErr_o),
        .ldqState_o      (ldqState_o)
`ifdef LDQ_OCCUPANCY_STATS_EN
        ,
        .ldqPeak_o        (ldqPeak_o),
        .ldqStallCycles_o (ldqStallCycles_o)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    int assertCnt = 0;
    int failCnt   = 0;

    logic [L-1:0] exp_q[$];   // entry indices currently allocated, oldest first
    int  modelHead;
    bit  modelErr;
    int  modelMode;
    int  modelPeak;
    int  modelStallCycles;
    bit  expAck;
    bit  expStall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        exp_q.delete();
        modelHead        = 0;
        modelErr         = 1'b0;
        modelMode        = M_RUN;
        modelPeak        = 0;
        modelStallCycles = 0;
    endtask

    task automatic checkRegs(input string ctx);
        check({ctx, ".head"},  ldqHead_o,   modelHead);
        check({ctx, ".tail"},  ldqTail_o,   (modelHead + exp_q.size()) % D);
        check({ctx, ".insts"}, ldqInsts_o,  exp_q.size());
        check({ctx, ".empty"}, ldqEmpty_o,  exp_q.size() == 0);
        check({ctx, ".err"},   commitErr_o, modelErr);
        check({ctx, ".state"}, ldqState_o,  modelMode);
`ifdef LDQ_OCCUPANCY_STATS_EN
        check({ctx, ".peak"},  ldqPeak_o,        modelPeak);
        check({ctx, ".stallc"}, ldqStallCycles_o, modelStallCycles);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic setIdle();
        dispatchReady_i = 1'b0;
        {inst3Load_i, inst2Load_i, inst1Load_i, inst0Load_i} = 4'b0000;
        commitCnt_i   = 2'd0;
        recoverFlag_i = 1'b0;
    endtask

    // Asserts reset away from any clock edge and checks the outputs before
    // the next edge arrives; ends at a falling edge with reset released.
    task automatic resetDut(input string ctx);
        setIdle();
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkRegs(ctx);
        check({ctx, ".ack"},   dispatchAck_o, 0);
        check({ctx, ".stall"}, ldqStall_o,    0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One cycle: drive at the falling edge, check handshake outputs, take the
    // rising edge, update the model, check registered outputs.
    task automatic step(input bit rdy, input bit [3:0] ld, input bit [1:0] cm, input bit rc);
        int nl;
        int eff;
        int sz;
        dispatchReady_i = rdy;
        {inst3Load_i, inst2Load_i, inst1Load_i, inst0Load_i} = ld;
        commitCnt_i   = cm;
        recoverFlag_i = rc;
        #1;
        nl       = $countones(ld);
        expAck   = (modelMode != M_RECOVER) && rdy && !rc && (nl <= D - exp_q.size());
        expStall = rdy && !expAck;
        check("ack",   dispatchAck_o, expAck);
        check("stall", ldqStall_o,    expStall);
        @(posedge clk);
        sz  = exp_q.size();
        eff = (int'(cm) < sz) ? int'(cm) : sz;
        if (int'(cm) > sz) modelErr = 1'b1;
        for (int i = 0; i < eff; i++) begin
            void'(exp_q.pop_front());
            modelHead = (modelHead + 1) % D;
        end
        if (rc) begin
            exp_q.delete();
            modelMode = M_RECOVER;
        end else begin
            if (expAck) begin
                for (int i = 0; i < nl; i++) begin
                    exp_q.push_back(L'((modelHead + exp_q.size()) % D));
                end
            end
            if (modelMode == M_RUN)        modelMode = expStall ? M_STALL : M_RUN;
            else if (modelMode == M_STALL) modelMode = expAck ? M_RUN : M_STALL;
            else                           modelMode = M_RUN;
        end
        if (expStall) modelStallCycles++;
        if (exp_q.size() > modelPeak) modelPeak = exp_q.size();
        #1;
        checkRegs("cyc");
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Four full bundles from reset.
        resetDut("rst0");
        repeat (4) step(1, 4'hF, 2'd0, 0);
        check("b4.tail",  ldqTail_o,  16);
        check("b4.insts", ldqInsts_o, 16);

        // Occupancy 30: 3-load bundle stalls even with 2 commits, then fits.
        repeat (3) step(1, 4'hF, 2'd0, 0);
        step(1, 4'b0011, 2'd0, 0);
        check("o30.insts", ldqInsts_o, 30);
        step(1, 4'b0111, 2'd2, 0);
        check("o30.state", ldqState_o, M_STALL);
        check("o28.insts", ldqInsts_o, 28);
        step(1, 4'b0111, 2'd0, 0);
        check("o31.insts", ldqInsts_o, 31);
        check("o31.state", ldqState_o, M_RUN);

        // Pointer wrap at head=tail=30.
        resetDut("rst1");
        repeat (7) step(1, 4'hF, 2'd0, 0);
        step(1, 4'b1100, 2'd0, 0);
        repeat (15) step(0, 4'h0, 2'd2, 0);
        check("w.head0", ldqHead_o, 30);
        check("w.tail0", ldqTail_o, 30);
        step(1, 4'hF, 2'd0, 0);
        check("w.tail", ldqTail_o, 2);
        repeat (2) step(0, 4'h0, 2'd2, 0);
        check("w.head",  ldqHead_o,  2);
        check("w.empty", ldqEmpty_o, 1);

        // Recover with concurrent commit and bundle.
        resetDut("rst2");
        repeat (3) step(1, 4'hF, 2'd0, 0);
        step(1, 4'b0111, 2'd0, 0);
        step(0, 4'h0, 2'd2, 0);
        step(0, 4'h0, 2'd2, 0);
        step(0, 4'h0, 2'd1, 0);
        check("r.head0",  ldqHead_o,  5);
        check("r.insts0", ldqInsts_o, 10);
        step(1, 4'hF, 2'd2, 1);
        check("r.head",  ldqHead_o,  7);
        check("r.tail",  ldqTail_o,  7);
        check("r.insts", ldqInsts_o, 0);
        check("r.state", ldqState_o, M_RECOVER);
        step(1, 4'hF, 2'd0, 0);
        check("r.bubble", ldqInsts_o, 0);
        check("r.run",    ldqState_o, M_RUN);

        // Over-commit clamps and sets the sticky error.
        resetDut("rst3");
        step(1, 4'b0001, 2'd0, 0);
        step(0, 4'h0, 2'd2, 0);
        check("oc.insts", ldqInsts_o,  0);
        check("oc.head",  ldqHead_o,   1);
        check("oc.err",   commitErr_o, 1);
        repeat (3) step(1, 4'b0101, 2'd1, 0);
        check("oc.sticky", commitErr_o, 1);

        // Asynchronous reset while full and stalled.
        resetDut("rst4");
        repeat (8) step(1, 4'hF, 2'd0, 0);
        step(1, 4'b0001, 2'd0, 0);
        check("f.insts", ldqInsts_o, 32);
        check("f.state", ldqState_o, M_STALL);
        resetDut("rstFull");

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 2)),
                 $urandom_range(0, 31) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
